// File: rtl/la_oen_seq_if.sv
// Pad-control bundle between the core and the output-enable sequencer.
// The core drives the request side; the sequencer returns the enables and status.
interface la_oen_seq_if #(
  parameter int N  = 4,
  parameter int CW = 8
);
  logic          en;
  logic          kill;
  logic [CW-1:0] gap;
  logic [N-1:0]  oe;
  logic          busy;
  logic          done;

  modport master (
    output en,
    output kill,
    output gap,
    input  oe,
    input  busy,
    input  done
  );

  modport slave (
    input  en,
    input  kill,
    input  gap,
    output oe,
    output busy,
    output done
  );
endinterface

// File: rtl/la_oen_seq.sv
// Output-enable sequencer: ramps N pad groups on one at a time with a programmable
// gap between steps, and ramps them off in reverse order, to limit switching current.
//
// state | meaning
// IDLE  | all groups off, waiting for en
// UP    | ramping on, one group per gap+1 cycles
// ON    | all groups on
// DOWN  | ramping off, highest group first
module la_oen_seq #(
  parameter int N    = 4,
  parameter int CW   = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic        clk,
  input  logic        nreset,
  la_oen_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    ON   = 2'd2,
    DOWN = 2'd3
  } state_t;

  localparam logic [N-1:0]  OE_ALL  = '1;
  localparam logic [N-1:0]  OE_NONE = '0;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  oe_q, oe_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [N-1:0]  oe_up;
  logic [N-1:0]  oe_dn;
  logic          unused_prop;

  assign unused_prop = |PROP;

  // oe stays thermometer coded, so a step is just a shift in either direction.
  assign oe_up = {oe_q[N-2:0], 1'b1};
  assign oe_dn = {1'b0, oe_q[N-1:1]};

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      oe_q    <= OE_NONE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      oe_q    <= oe_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    oe_d    = oe_q;
    cnt_d   = cnt_q;
    if (bus.kill) begin
      state_d = IDLE;
      oe_d    = OE_NONE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.en) begin
            oe_d    = oe_up;
            cnt_d   = bus.gap;
            state_d = (oe_up == OE_ALL) ? ON : UP;
          end
        end
        UP: begin
          // A direction change wins over a pending forward step on the same edge.
          if (!bus.en) begin
            oe_d    = oe_dn;
            cnt_d   = bus.gap;
            state_d = (oe_dn == OE_NONE) ? IDLE : DOWN;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            oe_d    = oe_up;
            cnt_d   = bus.gap;
            state_d = (oe_up == OE_ALL) ? ON : UP;
          end
        end
        ON: begin
          if (!bus.en) begin
            oe_d    = oe_dn;
            cnt_d   = bus.gap;
            state_d = (oe_dn == OE_NONE) ? IDLE : DOWN;
          end
        end
        DOWN: begin
          if (bus.en) begin
            oe_d    = oe_up;
            cnt_d   = bus.gap;
            state_d = (oe_up == OE_ALL) ? ON : UP;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            oe_d    = oe_dn;
            cnt_d   = bus.gap;
            state_d = (oe_dn == OE_NONE) ? IDLE : DOWN;
          end
        end
        default: begin
          state_d = IDLE;
          oe_d    = OE_NONE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Status flags are registered alongside the state so they line up with oe.
  always_comb begin
    busy_d = (state_d == UP) || (state_d == DOWN);
    done_d = (state_d == ON);
  end

  assign bus.oe   = oe_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_la_oen_seq.sv
// Bench for la_oen_seq: directed scenarios push expected outputs per clock edge
// into a scoreboard; a negedge monitor pops and compares them against the DUT.
module tb_la_oen_seq;

  logic clk = 1'b0;
  logic nreset;
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;
  int   t;

  la_oen_seq_if #(.N(4), .CW(8)) bus ();

  la_oen_seq #(.N(4), .CW(8), .PROP("DEFAULT")) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  int          q_cyc[$];
  logic [3:0]  q_oe[$];
  logic        q_busy[$];
  logic        q_done[$];
  string       q_name[$];

  task automatic ex(input int c, input logic [3:0] o, input logic b, input logic d,
                    input string nm);
    q_cyc.push_back(c);
    q_oe.push_back(o);
    q_busy.push_back(b);
    q_done.push_back(d);
    q_name.push_back(nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= edge_n) begin
      total = total + 1;
      if (q_cyc[0] != edge_n || bus.oe !== q_oe[0] || bus.busy !== q_busy[0]
          || bus.done !== q_done[0]) begin
        bad = bad + 1;
        $display("FAIL %s edge %0d (due %0d): got oe=%b busy=%b done=%b, want oe=%b busy=%b done=%b",
                 q_name[0], edge_n, q_cyc[0], bus.oe, bus.busy, bus.done,
                 q_oe[0], q_busy[0], q_done[0]);
      end
      void'(q_cyc.pop_front());
      void'(q_oe.pop_front());
      void'(q_busy.pop_front());
      void'(q_done.pop_front());
      void'(q_name.pop_front());
    end
  end

  initial begin
    nreset   = 1'b0;
    bus.en   = 1'b0;
    bus.kill = 1'b0;
    bus.gap  = 8'd0;
    tick(2);
    ex(edge_n, 4'b0000, 1'b0, 1'b0, "reset");
    nreset = 1'b1;
    ex(edge_n + 1, 4'b0000, 1'b0, 1'b0, "idle_en0");
    tick(1);

    // gap=0 ramp up, one step per edge
    bus.en = 1'b1;
    t = edge_n + 1;
    ex(t,     4'b0001, 1'b1, 1'b0, "up0_s0");
    ex(t + 1, 4'b0011, 1'b1, 1'b0, "up0_s1");
    ex(t + 2, 4'b0111, 1'b1, 1'b0, "up0_s2");
    ex(t + 3, 4'b1111, 1'b0, 1'b1, "up0_on");
    ex(t + 5, 4'b1111, 1'b0, 1'b1, "on_hold");
    tick(6);

    // gap=3 ramp down then up, 4-cycle spacing
    bus.gap = 8'd3;
    bus.en  = 1'b0;
    t = edge_n + 1;
    ex(t,      4'b0111, 1'b1, 1'b0, "dn3_s0");
    ex(t + 3,  4'b0111, 1'b1, 1'b0, "dn3_hold");
    ex(t + 4,  4'b0011, 1'b1, 1'b0, "dn3_s1");
    ex(t + 8,  4'b0001, 1'b1, 1'b0, "dn3_s2");
    ex(t + 11, 4'b0001, 1'b1, 1'b0, "dn3_hold2");
    ex(t + 12, 4'b0000, 1'b0, 1'b0, "dn3_idle");
    tick(13);
    bus.en = 1'b1;
    t = edge_n + 1;
    ex(t,      4'b0001, 1'b1, 1'b0, "up3_s0");
    ex(t + 3,  4'b0001, 1'b1, 1'b0, "up3_hold");
    ex(t + 4,  4'b0011, 1'b1, 1'b0, "up3_s1");
    ex(t + 8,  4'b0111, 1'b1, 1'b0, "up3_s2");
    ex(t + 11, 4'b0111, 1'b1, 1'b0, "up3_hold2");
    ex(t + 12, 4'b1111, 1'b0, 1'b1, "up3_on");
    tick(13);

    bus.gap = 8'd0;
    bus.en  = 1'b0;
    t = edge_n + 1;
    ex(t,     4'b0111, 1'b1, 1'b0, "dn0_s0");
    ex(t + 1, 4'b0011, 1'b1, 1'b0, "dn0_s1");
    ex(t + 2, 4'b0001, 1'b1, 1'b0, "dn0_s2");
    ex(t + 3, 4'b0000, 1'b0, 1'b0, "dn0_idle");
    tick(4);

    // reversal during UP with gap=2
    bus.gap = 8'd2;
    bus.en  = 1'b1;
    t = edge_n + 1;
    ex(t,     4'b0001, 1'b1, 1'b0, "rev_s0");
    ex(t + 3, 4'b0011, 1'b1, 1'b0, "rev_s1");
    ex(t + 4, 4'b0001, 1'b1, 1'b0, "rev_back");
    ex(t + 6, 4'b0001, 1'b1, 1'b0, "rev_hold");
    ex(t + 7, 4'b0000, 1'b0, 1'b0, "rev_idle");
    tick(4);
    bus.en = 1'b0;
    tick(4);

    // kill during UP, held with en=1, then release
    bus.en = 1'b1;
    t = edge_n + 1;
    ex(t + 3, 4'b0011, 1'b1, 1'b0, "pre_kill");
    ex(t + 4, 4'b0000, 1'b0, 1'b0, "kill");
    ex(t + 6, 4'b0000, 1'b0, 1'b0, "kill_held");
    ex(t + 7, 4'b0001, 1'b1, 1'b0, "kill_release");
    ex(t + 8, 4'b0000, 1'b0, 1'b0, "rev_to_idle");
    tick(4);
    bus.kill = 1'b1;
    tick(3);
    bus.kill = 1'b0;
    tick(1);
    bus.en = 1'b0;
    tick(1);

    // reset during DOWN
    bus.gap = 8'd0;
    bus.en  = 1'b1;
    t = edge_n + 1;
    ex(t + 3,  4'b1111, 1'b0, 1'b1, "pre_rst_on");
    ex(t + 4,  4'b0111, 1'b1, 1'b0, "pre_rst_dn");
    ex(t + 5,  4'b0000, 1'b0, 1'b0, "rst_mid");
    ex(t + 6,  4'b0000, 1'b0, 1'b0, "rst_held");
    ex(t + 7,  4'b0001, 1'b1, 1'b0, "rst_release");
    ex(t + 10, 4'b1111, 1'b0, 1'b1, "rst_reramp");
    tick(4);
    bus.en = 1'b0;
    tick(1);
    nreset = 1'b0;
    bus.en = 1'b1;
    tick(2);
    nreset = 1'b1;
    tick(4);

    // en change coinciding with cnt==0, then toggling every cycle
    bus.gap = 8'd1;
    bus.en  = 1'b0;
    t = edge_n + 1;
    ex(t,     4'b0111, 1'b1, 1'b0, "co_dn");
    ex(t + 1, 4'b0111, 1'b1, 1'b0, "co_cnt0");
    ex(t + 2, 4'b1111, 1'b0, 1'b1, "co_rev");
    ex(t + 3, 4'b0111, 1'b1, 1'b0, "tog_dn");
    ex(t + 4, 4'b1111, 1'b0, 1'b1, "tog_up");
    tick(2);
    bus.en = 1'b1;
    tick(1);
    bus.en = 1'b0;
    tick(1);
    bus.en = 1'b1;
    tick(1);

    // kill from ON, then gap changed mid-interval
    bus.kill = 1'b1;
    t = edge_n + 1;
    ex(t,     4'b0000, 1'b0, 1'b0, "kill_on");
    ex(t + 1, 4'b0000, 1'b0, 1'b0, "kill_idle");
    tick(1);
    bus.kill = 1'b0;
    bus.en   = 1'b0;
    bus.gap  = 8'd5;
    tick(1);
    bus.en = 1'b1;
    t = edge_n + 1;
    ex(t,      4'b0001, 1'b1, 1'b0, "gch_s0");
    ex(t + 5,  4'b0001, 1'b1, 1'b0, "gch_hold");
    ex(t + 6,  4'b0011, 1'b1, 1'b0, "gch_s1");
    ex(t + 7,  4'b0011, 1'b1, 1'b0, "gch_hold2");
    ex(t + 8,  4'b0111, 1'b1, 1'b0, "gch_s2");
    ex(t + 10, 4'b1111, 1'b0, 1'b1, "gch_on");
    tick(2);
    bus.gap = 8'd1;
    tick(9);

    // maximum gap: 256-cycle interval
    bus.gap = 8'hFF;
    bus.en  = 1'b0;
    t = edge_n + 1;
    ex(t,       4'b0111, 1'b1, 1'b0, "gmax_s0");
    ex(t + 255, 4'b0111, 1'b1, 1'b0, "gmax_hold");
    ex(t + 256, 4'b0011, 1'b1, 1'b0, "gmax_s1");
    tick(257);

    for (int i = 0; i < 10 && q_cyc.size() > 0; i++) tick(1);
    if (q_cyc.size() > 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q_cyc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
